// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Runs byte/halfword/word loads and stores over a single-outstanding,
// wait-stated data bus (big-endian byte lanes) and stalls the pipeline
// until the access completes. Non-memory ops pass straight through.
`timescale 1ns/1ps
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM pipeline register
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  // writeback towards mem_wb
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  // pipeline control / exceptions
  output logic        stallreq,
  output logic        misalign,
  // data bus
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  // decoded operation
  logic is_load, is_store, is_mem;
  logic acc_byte, acc_half, acc_word;
  logic ld_signed;
  logic addr_misaligned;

  // bus-side views of the current op
  logic [3:0]  lane_sel;
  logic [31:0] st_data;
  logic [31:0] ld_result;

  // raw (pre-reset-gating) outputs
  logic [31:0] out_wdata;
  logic [4:0]  out_wd;
  logic        out_wreg;
  logic        out_whilo;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        out_stall;
  logic        out_misalign;
  logic        out_req;
  logic        out_we;
  logic [31:0] out_addr;
  logic [3:0]  out_sel;
  logic [31:0] out_bwdata;

  // Decode aluop into access kind, direction and sign handling
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    acc_byte  = 1'b0;
    acc_half  = 1'b0;
    acc_word  = 1'b0;
    ld_signed = 1'b0;
    case (ex_aluop)
      OP_LB:   begin is_load  = 1'b1; acc_byte = 1'b1; ld_signed = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; acc_byte = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; acc_half = 1'b1; ld_signed = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; acc_half = 1'b1; end
      OP_LW:   begin is_load  = 1'b1; acc_word = 1'b1; end
      OP_SB:   begin is_store = 1'b1; acc_byte = 1'b1; end
      OP_SH:   begin is_store = 1'b1; acc_half = 1'b1; end
      OP_SW:   begin is_store = 1'b1; acc_word = 1'b1; end
      default: ;
    endcase
    is_mem          = is_load | is_store;
    addr_misaligned = (acc_half & ex_mem_addr[0]) |
                      (acc_word & (ex_mem_addr[1:0] != 2'b00));
  end

  // Byte-lane select and replicated store data (big-endian: offset 0 is bits 31:24)
  always_comb begin
    lane_sel = 4'b0000;
    st_data  = ex_reg2;
    if (acc_word) begin
      lane_sel = 4'b1111;
      st_data  = ex_reg2;
    end else if (acc_half) begin
      lane_sel = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      st_data  = {2{ex_reg2[15:0]}};
    end else if (acc_byte) begin
      lane_sel = 4'b1000 >> ex_mem_addr[1:0];
      st_data  = {4{ex_reg2[7:0]}};
    end
  end

  // Split the latched read word into its four big-endian byte lanes
  logic [7:0] rd_lane [4];
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = rdata_q[31-8*gi -: 8];
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Format the latched read data: pick lane(s), then sign- or zero-extend
  always_comb begin
    ld_byte   = rd_lane[ex_mem_addr[1:0]];
    ld_half   = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    ld_result = rdata_q;
    if (acc_half) begin
      ld_result = ld_signed ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
    end else if (acc_byte) begin
      ld_result = ld_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
    end
  end

  // State and read-data registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and raw outputs; ack only matters while a request is out
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    out_wdata    = ex_wdata;
    out_wd       = ex_wd;
    out_wreg     = ex_wreg;
    out_whilo    = ex_whilo;
    out_hi       = ex_hi;
    out_lo       = ex_lo;
    out_stall    = 1'b0;
    out_misalign = 1'b0;
    out_req      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          if (addr_misaligned) begin
            // fault: no bus access, suppress the writeback, let the pipe move
            out_misalign = 1'b1;
            out_wreg     = 1'b0;
          end else begin
            out_req   = 1'b1;
            out_stall = 1'b1;
            out_wreg  = 1'b0;
            if (dbus_ack) begin
              rdata_d = dbus_rdata;
              state_d = ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
      end
      ST_BUSY: begin
        out_req   = 1'b1;
        out_stall = 1'b1;
        out_wreg  = 1'b0;
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // one result cycle, then back to IDLE so the held op is not re-issued
        state_d = ST_IDLE;
        if (is_load) begin
          out_wdata = ld_result;
        end else if (is_store) begin
          out_wreg = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus fields are only presented alongside a request
  always_comb begin
    out_we     = 1'b0;
    out_addr   = '0;
    out_sel    = 4'b0000;
    out_bwdata = '0;
    if (out_req) begin
      out_we     = is_store;
      out_addr   = {ex_mem_addr[31:2], 2'b00};
      out_sel    = lane_sel;
      out_bwdata = is_store ? st_data : 32'h0;
    end
  end

  // Output stage: everything reads as zero for as long as reset is high
  always_comb begin
    if (rst) begin
      mem_wdata  = '0;
      mem_wd     = '0;
      mem_wreg   = 1'b0;
      mem_whilo  = 1'b0;
      mem_hi     = '0;
      mem_lo     = '0;
      stallreq   = 1'b0;
      misalign   = 1'b0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = '0;
      dbus_sel   = 4'b0000;
      dbus_wdata = '0;
    end else begin
      mem_wdata  = out_wdata;
      mem_wd     = out_wd;
      mem_wreg   = out_wreg;
      mem_whilo  = out_whilo;
      mem_hi     = out_hi;
      mem_lo     = out_lo;
      stallreq   = out_stall;
      misalign   = out_misalign;
      dbus_req   = out_req;
      dbus_we    = out_we;
      dbus_addr  = out_addr;
      dbus_sel   = out_sel;
      dbus_wdata = out_bwdata;
    end
  end

endmodule
